sr_button_driver: RTL and testbench

- Drives a clocked, glitch-free SR storage element from two raw Basys3 push-buttons or switches. The set input is typically btnU/SW0 and the reset input btnD/SW1.
- Each input is synchronised and debounced, and produces a one-cycle edge pulse.
- A registered Q/Q_bar pair replaces the free-running cross-coupled latch. The illegal S=R=1 case is resolved deterministically and flagged.
- Sits between the board I/O constraints and the LED outputs in the lab top level.

---
 rtl/sr_lab_pkg.sv | 30 +++
 rtl/debounce_sync.sv | 71 +++++++
 rtl/sr_button_driver.sv | 91 +++++++++
 tb/tb_sr_button_driver.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_lab_pkg.sv
// Shared constants and helpers for the SR storage-element lab.
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles needed to accept a new button level
//   CLK_HZ                  : board system clock frequency
//   Q_RESET_VAL             : value of Q after reset
//   sr_next_q()             : next stored state from debounced S/R levels
package sr_lab_pkg;

    localparam int       DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int       CLK_HZ                  = 100000000;
    localparam logic     Q_RESET_VAL             = 1'b0;

    // Next value of the stored bit. When both inputs are high the result is
    // fixed by reset_wins so the illegal case never oscillates.
    function automatic logic sr_next_q(
        input logic q,
        input logic s,
        input logic r,
        input logic reset_wins
    );
        logic q_next;
        case ({s, r})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11:   q_next = ~reset_wins;
            default: q_next = q;
        endcase
        return q_next;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser, debounce counter and rising-edge pulse for one
// raw button/switch input.
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   raw        : asynchronous raw input
//   level      : debounced level (registered)
//   rise_pulse : one-cycle pulse, one cycle after level rises (registered)
module debounce_sync
    import sr_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_prev_r;
    logic             pulse_r;

    // Bring the raw input into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed from the current level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Registered rising-edge detector on the debounced level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_prev_r <= 1'b0;
            pulse_r      <= 1'b0;
        end else begin
            level_prev_r <= level_r;
            pulse_r      <= level_r & ~level_prev_r;
        end
    end

    assign level      = level_r;
    assign rise_pulse = pulse_r;

endmodule

// File: rtl/sr_button_driver.sv
// Glitch-free registered SR storage element driven by two raw buttons.
//   clk      : 100 MHz system clock, rising edge
//   rst_n    : synchronous active-low reset
//   S_raw    : raw set input       R_raw   : raw reset input
//   S_db     : debounced set       R_db    : debounced reset
//   S_pulse  : set rise pulse      R_pulse : reset rise pulse
//   Q, Q_bar : stored state and its complement (registered together)
//   invalid  : high while both debounced inputs are high
module sr_button_driver
    import sr_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit RESET_WINS      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic S_raw,
    input  logic R_raw,
    output logic S_db,
    output logic R_db,
    output logic S_pulse,
    output logic R_pulse,
    output logic Q,
    output logic Q_bar,
    output logic invalid
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic s_db_s;
    logic r_db_s;
    logic q_next_s;
    logic invalid_next_s;
    logic q_r;
    logic q_bar_r;
    logic invalid_r;

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (S_raw),
        .level      (s_db_s),
        .rise_pulse (S_pulse)
    );

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (R_raw),
        .level      (r_db_s),
        .rise_pulse (R_pulse)
    );

    // Next state and illegal-input flag from the current debounced levels.
    always_comb begin
        q_next_s       = sr_next_q(q_r, s_db_s, r_db_s, RESET_WINS);
        invalid_next_s = 1'b0;
        if (s_db_s && r_db_s) begin
            invalid_next_s = 1'b1;
        end else begin
            invalid_next_s = 1'b0;
        end
    end

    // State register; Q_bar is loaded from the same next value so the pair
    // can never be equal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r       <= Q_RESET_VAL;
            q_bar_r   <= ~Q_RESET_VAL;
            invalid_r <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            q_bar_r   <= ~q_next_s;
            invalid_r <= invalid_next_s;
        end
    end

    assign S_db    = s_db_s;
    assign R_db    = r_db_s;
    assign Q       = q_r;
    assign Q_bar   = q_bar_r;
    assign invalid = invalid_r;

endmodule

// File: tb/tb_sr_button_driver.sv
// Self-checking bench for sr_button_driver with DEBOUNCE_CYCLES=4. Two DUTs
// share the inputs: one with RESET_WINS=1, one with RESET_WINS=0.
module tb_sr_button_driver;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, S_raw, R_raw;
    logic S_db, R_db, S_pulse, R_pulse, Q, Q_bar, invalid;
    logic S_db0, R_db0, S_pulse0, R_pulse0, Q0, Q_bar0, invalid0;

    int errors = 0;
    int checks = 0;

    sr_button_driver #(.DEBOUNCE_CYCLES(N), .RESET_WINS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .S_raw(S_raw), .R_raw(R_raw),
        .S_db(S_db), .R_db(R_db), .S_pulse(S_pulse), .R_pulse(R_pulse),
        .Q(Q), .Q_bar(Q_bar), .invalid(invalid));

    sr_button_driver #(.DEBOUNCE_CYCLES(N), .RESET_WINS(1'b0)) dut_rw0 (
        .clk(clk), .rst_n(rst_n), .S_raw(S_raw), .R_raw(R_raw),
        .S_db(S_db0), .R_db(R_db0), .S_pulse(S_pulse0), .R_pulse(R_pulse0),
        .Q(Q0), .Q_bar(Q_bar0), .invalid(invalid0));

    // Reference model: a level is accepted once the synchronised value
    // (raw delayed by two samples) has disagreed with it on each of the last
    // N edges. Index 0 = set input, 1 = reset input.
    bit m_d[2];
    bit m_rose[2];
    bit m_pulse[2];
    bit m_q1, m_q0, m_inv;
    bit samp[2][2];
    int nsamp[2];
    bit xwin[2][N];
    int xcnt[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_d[i] = 1'b0; m_rose[i] = 1'b0; m_pulse[i] = 1'b0;
            samp[i][0] = 1'b0; samp[i][1] = 1'b0; nsamp[i] = 0; xcnt[i] = 0;
            for (int j = 0; j < N; j++) xwin[i][j] = 1'b0;
        end
        m_q1 = 1'b0; m_q0 = 1'b0; m_inv = 1'b0;
    endtask

    task automatic model_edge();
        bit raw_v[2];
        bit x_pre;
        bit all_diff;
        bit s, r;
        raw_v[0] = S_raw; raw_v[1] = R_raw;
        if (!rst_n) begin
            model_reset();
        end else begin
            s = m_d[0]; r = m_d[1];
            if (s && !r) begin m_q1 = 1'b1; m_q0 = 1'b1; end
            else if (r && !s) begin m_q1 = 1'b0; m_q0 = 1'b0; end
            else if (s && r) begin m_q1 = 1'b0; m_q0 = 1'b1; end
            m_inv = s && r;
            for (int i = 0; i < 2; i++) begin
                m_pulse[i] = m_rose[i];
                m_rose[i]  = 1'b0;
                x_pre = (nsamp[i] >= 2) ? samp[i][1] : 1'b0;
                samp[i][1] = samp[i][0];
                samp[i][0] = raw_v[i];
                if (nsamp[i] < 2) nsamp[i]++;
                for (int j = N - 1; j > 0; j--) xwin[i][j] = xwin[i][j-1];
                xwin[i][0] = x_pre;
                if (xcnt[i] < N) xcnt[i]++;
                all_diff = (xcnt[i] == N);
                for (int j = 0; j < N; j++) if (xwin[i][j] == m_d[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_d[i]    = ~m_d[i];
                    m_rose[i] = m_d[i];
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_vec();
        return {m_d[0], m_d[1], m_pulse[0], m_pulse[1], m_q1, ~m_q1, m_inv,
                m_d[0], m_d[1], m_pulse[0], m_pulse[1], m_q0, ~m_q0, m_inv};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {S_db, R_db, S_pulse, R_pulse, Q, Q_bar, invalid,
                S_db0, R_db0, S_pulse0, R_pulse0, Q0, Q_bar0, invalid0};
    endfunction

    // One clock: model advances from the inputs present at the edge, then
    // outputs are sampled 1 ns after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; S_raw = 1'b1; R_raw = 1'b1;
        model_reset();
        repeat (3) step();
        checks++;
        if ({S_db, R_db, S_pulse, R_pulse, Q, Q_bar, invalid} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {S_db, R_db, S_pulse, R_pulse, Q, Q_bar, invalid}, 7'b0000010);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_model edge=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (k <= 5) begin
                checks++;
                if ({S_db, R_db, S_pulse, R_pulse, Q, Q_bar, invalid} !== 7'b0000010) begin
                    errors++;
                    $display("FAIL reset_release_quiet edge=%0d got=%b exp=%b", k, {S_db, R_db, S_pulse, R_pulse, Q, Q_bar, invalid}, 7'b0000010);
                end
            end
        end
        checks++;
        if ({invalid, Q, Q_bar, Q0, Q_bar0, S_pulse, R_pulse} !== 7'b1011011) begin
            errors++;
            $display("FAIL reset_illegal_edge7 got=%b exp=%b", {invalid, Q, Q_bar, Q0, Q_bar0, S_pulse, R_pulse}, 7'b1011011);
        end
        // Release both together: each DUT keeps its resolved value.
        S_raw = 1'b0; R_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release_model got=%b exp=%b", obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({S_db, R_db, invalid, Q, Q0} !== 5'b00001) begin
            errors++;
            $display("FAIL release_both_hold got=%b exp=%b", {S_db, R_db, invalid, Q, Q0}, 5'b00001);
        end
    endtask

    task automatic test_set();
        int at_db, at_q, npulse, at_pulse;
        at_db = -1; at_q = -1; npulse = 0; at_pulse = -1;
        S_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL set_model edge=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (S_db === 1'b1 && at_db < 0) at_db = k;
            if (Q === 1'b1 && Q_bar === 1'b0 && at_q < 0) at_q = k;
            if (S_pulse === 1'b1) begin npulse++; at_pulse = k; end
        end
        checks++;
        if (at_db != N + 2) begin errors++; $display("FAIL set_db_latency got=%0d exp=%0d", at_db, N + 2); end
        checks++;
        if (at_q != N + 3) begin errors++; $display("FAIL set_q_latency got=%0d exp=%0d", at_q, N + 3); end
        checks++;
        if (npulse != 1 || at_pulse != N + 3) begin
            errors++;
            $display("FAIL set_pulse count=%0d edge=%0d exp count=1 edge=%0d", npulse, at_pulse, N + 3);
        end
        S_raw = 1'b0;
        for (int k = 0; k < 12; k++) step();
        checks++;
        if ({S_db, S_pulse, Q, Q_bar} !== 4'b0010) begin
            errors++;
            $display("FAIL set_hold_after_release got=%b exp=%b", {S_db, S_pulse, Q, Q_bar}, 4'b0010);
        end
    endtask

    task automatic test_bounce();
        bit seen;
        logic [7:0] pat;
        seen = 1'b0;
        pat = 8'b00110011;
        for (int k = 0; k < 18; k++) begin
            S_raw = (k < 8) ? pat[k] : 1'b0;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_model step=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (S_db !== 1'b0 || S_pulse !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || Q !== 1'b1) begin
            errors++;
            $display("FAIL bounce_reject seen=%0d q=%b exp seen=0 q=1", seen, Q);
        end
    endtask

    task automatic test_reset_path();
        int at_db, at_q, npulse;
        at_db = -1; at_q = -1; npulse = 0;
        for (int k = 1; k <= 22; k++) begin
            R_raw = (k <= 10) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rpath_model edge=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (R_db === 1'b1 && at_db < 0) at_db = k;
            if (Q === 1'b0 && at_q < 0) at_q = k;
            if (R_pulse === 1'b1) npulse++;
        end
        checks++;
        if (at_db != N + 2 || at_q != N + 3 || npulse != 1) begin
            errors++;
            $display("FAIL rpath_timing db=%0d q=%0d pulses=%0d exp %0d %0d 1", at_db, at_q, npulse, N + 2, N + 3);
        end
    endtask

    task automatic test_illegal();
        int at_fall;
        bit checked_after;
        at_fall = -1; checked_after = 1'b0;
        S_raw = 1'b1; R_raw = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL illegal_model got=%b exp=%b", obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({invalid, Q, Q_bar, invalid0, Q0, Q_bar0} !== 6'b101110) begin
            errors++;
            $display("FAIL illegal_resolve got=%b exp=%b", {invalid, Q, Q_bar, invalid0, Q0, Q_bar0}, 6'b101110);
        end
        R_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL illegal_release_model edge=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (at_fall > 0 && !checked_after) begin
                checked_after = 1'b1;
                checks++;
                if ({invalid, Q, Q_bar} !== 3'b010) begin
                    errors++;
                    $display("FAIL illegal_exit got=%b exp=%b", {invalid, Q, Q_bar}, 3'b010);
                end
            end
            if (R_db === 1'b0 && at_fall < 0) at_fall = k;
        end
        checks++;
        if (at_fall != N + 2 || !checked_after) begin
            errors++;
            $display("FAIL illegal_r_fall got=%0d exp=%0d", at_fall, N + 2);
        end
        S_raw = 1'b0;
        for (int k = 0; k < 12; k++) step();
    endtask

    task automatic test_reset_mid();
        int at_db;
        at_db = -1;
        S_raw = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({S_db, Q, Q_bar} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset_clear got=%b exp=%b", {S_db, Q, Q_bar}, 3'b001);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_model edge=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
            end
            if (S_db === 1'b1 && at_db < 0) at_db = k;
        end
        checks++;
        if (at_db != N + 2) begin errors++; $display("FAIL mid_full_delay got=%0d exp=%0d", at_db, N + 2); end
        S_raw = 1'b0;
        for (int k = 0; k < 12; k++) step();
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 120; seg++) begin
            S_raw = 1'($urandom_range(0, 1));
            R_raw = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
            hold  = (rst_n == 1'b0) ? 1 : int'($urandom_range(1, 9));
            for (int k = 0; k < hold; k++) begin
                step();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_model seg=%0d got=%b exp=%b", seg, obs_vec(), exp_vec());
                end
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; S_raw = 1'b0; R_raw = 1'b0;
        model_reset();
        test_reset();
        test_set();
        test_bounce();
        test_reset_path();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
